// File: rtl/data_memory_reader_pkg.sv
// Shared debug-unit constants: memory-reader FSM encodings and UART byte sizing.
package data_memory_reader_pkg;

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_REQ     = 3'd1;
    localparam logic [2:0] ST_LATCH   = 3'd2;
    localparam logic [2:0] ST_SEND    = 3'd3;
    localparam logic [2:0] ST_WAIT_TX = 3'd4;
    localparam logic [2:0] ST_NEXT    = 3'd5;
    localparam logic [2:0] ST_DONE    = 3'd6;

    typedef enum logic [2:0] {
        S_IDLE    = ST_IDLE,
        S_REQ     = ST_REQ,
        S_LATCH   = ST_LATCH,
        S_SEND    = ST_SEND,
        S_WAIT_TX = ST_WAIT_TX,
        S_NEXT    = ST_NEXT,
        S_DONE    = ST_DONE
    } state_e;

    localparam int DBG_NB_BYTE        = 8;
    localparam int DBG_NB_DATA        = 32;
    localparam int DBG_BYTES_PER_WORD = DBG_NB_DATA / DBG_NB_BYTE;

endpackage

// File: rtl/data_memory_reader.sv
// Debug-unit memory dump engine: reads every data-memory word in address order
// and streams its bytes, MSB first, to the UART transmitter one handshake at a time.
module data_memory_reader
    import data_memory_reader_pkg::*;
#(
    parameter int MEMORY_DEPTH = 32,
    parameter int NB_ADDR      = 5,
    parameter int NB_DATA      = 32,
    parameter int NB_BYTE      = DBG_NB_BYTE
) (
    input  logic               i_clock,
    input  logic               i_reset,
    input  logic               i_start,
    input  logic               i_tx_done,
    input  logic [NB_DATA-1:0] i_mem_data,
    output logic               o_mem_enable,
    output logic               o_mem_read,
    output logic [NB_ADDR-1:0] o_mem_address,
    output logic               o_tx_start,
    output logic [NB_BYTE-1:0] o_tx_data,
    output logic               o_busy,
    output logic               o_done
);

    localparam int BYTES_PER_WORD = NB_DATA / NB_BYTE;
    localparam int NB_BYTE_CNT    = (BYTES_PER_WORD > 1) ? $clog2(BYTES_PER_WORD) : 1;

    localparam logic [NB_ADDR-1:0]     LAST_ADDR = NB_ADDR'(MEMORY_DEPTH - 1);
    localparam logic [NB_ADDR-1:0]     ADDR_ONE  = {{(NB_ADDR-1){1'b0}}, 1'b1};
    localparam logic [NB_BYTE_CNT-1:0] LAST_BYTE = NB_BYTE_CNT'(BYTES_PER_WORD - 1);
    localparam logic [NB_BYTE_CNT-1:0] BYTE_ONE  = {{(NB_BYTE_CNT-1){1'b0}}, 1'b1};

    state_e                 state_r;
    logic [NB_ADDR-1:0]     addr_r;
    logic [NB_BYTE_CNT-1:0] byte_cnt_r;
    logic [NB_DATA-1:0]     shift_r;
    logic [NB_DATA-1:0]     shift_next_s;
    logic [NB_ADDR-1:0]     addr_inc_s;

    // Next word image after one byte has gone out, plus the following address.
    always_comb begin
        shift_next_s = shift_r << NB_BYTE;
        addr_inc_s   = addr_r + ADDR_ONE;
    end

    // Dump sequencer: state, counters, shift register and all registered outputs.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state_r       <= S_IDLE;
            addr_r        <= {NB_ADDR{1'b0}};
            byte_cnt_r    <= {NB_BYTE_CNT{1'b0}};
            shift_r       <= {NB_DATA{1'b0}};
            o_mem_enable  <= 1'b0;
            o_mem_read    <= 1'b0;
            o_mem_address <= {NB_ADDR{1'b0}};
            o_tx_start    <= 1'b0;
            o_tx_data     <= {NB_BYTE{1'b0}};
            o_busy        <= 1'b0;
            o_done        <= 1'b0;
        end else begin
            // Strobes are single-cycle; each transition re-asserts the one it needs.
            o_mem_enable <= 1'b0;
            o_mem_read   <= 1'b0;
            o_tx_start   <= 1'b0;
            o_done       <= 1'b0;
            case (state_r)
                S_IDLE: begin
                    if (i_start) begin
                        addr_r        <= {NB_ADDR{1'b0}};
                        byte_cnt_r    <= {NB_BYTE_CNT{1'b0}};
                        o_mem_address <= {NB_ADDR{1'b0}};
                        o_mem_enable  <= 1'b1;
                        o_mem_read    <= 1'b1;
                        o_busy        <= 1'b1;
                        state_r       <= S_REQ;
                    end
                end
                S_REQ: begin
                    state_r <= S_LATCH;
                end
                S_LATCH: begin
                    // Memory data is valid only now, so the first byte is taken straight from it.
                    shift_r    <= i_mem_data;
                    o_tx_data  <= i_mem_data[NB_DATA-1 -: NB_BYTE];
                    o_tx_start <= 1'b1;
                    state_r    <= S_SEND;
                end
                S_SEND: begin
                    state_r <= S_WAIT_TX;
                end
                S_WAIT_TX: begin
                    if (i_tx_done) begin
                        shift_r    <= shift_next_s;
                        byte_cnt_r <= byte_cnt_r + BYTE_ONE;
                        if (byte_cnt_r == LAST_BYTE) begin
                            state_r <= S_NEXT;
                        end else begin
                            o_tx_data  <= shift_next_s[NB_DATA-1 -: NB_BYTE];
                            o_tx_start <= 1'b1;
                            state_r    <= S_SEND;
                        end
                    end
                end
                S_NEXT: begin
                    // Compare before incrementing so the address never wraps.
                    if (addr_r == LAST_ADDR) begin
                        o_done  <= 1'b1;
                        state_r <= S_DONE;
                    end else begin
                        addr_r        <= addr_inc_s;
                        byte_cnt_r    <= {NB_BYTE_CNT{1'b0}};
                        o_mem_address <= addr_inc_s;
                        o_mem_enable  <= 1'b1;
                        o_mem_read    <= 1'b1;
                        state_r       <= S_REQ;
                    end
                end
                S_DONE: begin
                    o_busy  <= 1'b0;
                    state_r <= S_IDLE;
                end
                default: begin
                    o_busy  <= 1'b0;
                    state_r <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/data_memory_reader.md
# data_memory_reader

Sequential read-out engine for the pipeline's data memory. On a start pulse it walks every data-memory address from 0 to MEMORY_DEPTH-1 and issues a registered read for each word. It splits each returned word into bytes, MSB first, and hands them one at a time to the UART transmitter using a start/done handshake. It sits in the debug unit, between the data memory's read port and the UART TX, and is used to dump memory contents to the host after a program halts.

## Interface
- MEMORY_DEPTH, 32, number of words to dump; must satisfy MEMORY_DEPTH ≤ 2^NB_ADDR
- NB_ADDR, 5, data-memory address width
- NB_DATA, 32, data-memory word width; must be a multiple of NB_BYTE
- NB_BYTE, 8, UART payload width
- i_clock  in  1  system clock; all logic is rising-edge
- i_reset  in  1  synchronous, active-high reset
- i_start  in  1  single-cycle request to begin a dump; ignored unless the block is idle
- i_tx_done  in  1  single-cycle pulse from the UART TX when the current byte has been sent
- i_mem_data  in  NB_DATA  registered read data from data memory
- o_mem_enable  out  1  data-memory enable
- o_mem_read  out  1  data-memory read strobe
- o_mem_address  out  NB_ADDR  word address being read
- o_tx_start  out  1  single-cycle pulse requesting transmission of o_tx_data
- o_tx_data  out  NB_BYTE  byte to transmit; held stable from o_tx_start until the next SEND
- o_busy  out  1  high in every state except IDLE
- o_done  out  1  single-cycle pulse after the last byte of the last word is acknowledged

## Operation
- FSM states: IDLE, REQ, LATCH, SEND, WAIT_TX, NEXT, DONE.
- IDLE
  - All strobes are low.
  - When i_start=1: clear the address and byte counters, then go to REQ.
- REQ
  - Drive o_mem_enable=1, o_mem_read=1, and o_mem_address = address counter.
  - Go to LATCH.
- LATCH
  - Load i_mem_data into the word shift register. Memory output is valid this cycle.
  - Go to SEND.
- SEND
  - Pulse o_tx_start=1 for one cycle.
  - o_tx_data = shift register [NB_DATA-1 -: NB_BYTE].
  - Go to WAIT_TX.
- WAIT_TX
  - Hold until i_tx_done=1.
  - On i_tx_done: shift the register left by NB_BYTE and increment the byte counter.
  - If that was the last byte of the word (counter = NB_DATA/NB_BYTE-1): go to NEXT. Otherwise go to SEND.
- NEXT
  - If address = MEMORY_DEPTH-1: go to DONE.
  - Otherwise increment the address, clear the byte counter, and go to REQ.
- DONE
  - Pulse o_done=1 for one cycle.
  - Go to IDLE.
- Arithmetic rules:
  - The address counter never wraps; the comparison against MEMORY_DEPTH-1 happens before any increment.
  - The byte counter is clog2(NB_DATA/NB_BYTE) bits wide.
- Event-handling rules:
  - i_tx_done outside WAIT_TX is ignored, including a done pulse that coincides with o_tx_start.
  - i_start while busy is ignored. It does not restart the dump and is not queued.
  - i_start in the same cycle as o_done (DONE state) is ignored; the block must be back in IDLE before it accepts a new start.
  - o_mem_enable and o_mem_read are low in every state except REQ. The block never writes memory.

## Timing
- Reset values:
  - All outputs are 0.
  - FSM is in IDLE.
  - Counters and shift register are 0.
- Reset mid-dump: on the next edge, return to IDLE with all outputs 0. A byte already handed to the UART is abandoned and no o_done is generated.
- Memory read latency is 1 cycle: the address is registered at the end of REQ and data is sampled in LATCH.
- Start latency: if i_start is sampled at edge N, REQ occupies cycle N+1, LATCH N+2, and o_tx_start is high in cycle N+3.
- Per-byte cost: 1 SEND cycle plus k WAIT_TX cycles, where k ≥ 1 is the number of cycles until i_tx_done is sampled high.
- Per-word cost with k=1: REQ + LATCH + 4×2 + NEXT = 11 cycles.
- Full dump with default parameters and k=1: 32×11 + 1 (DONE) = 353 cycles from the first REQ to the o_done cycle inclusive.

## Structure
- Shared debug package holds:
  - FSM state encodings (3-bit localparams),
  - NB_BYTE,
  - bytes-per-word constant NB_DATA/NB_BYTE.
- The block is a single module with no sub-module. The UART TX and the data memory are instantiated by the debug-unit top level and connected to this block's ports.

## Test plan
- Memory preloaded with word[i] = 0xA0B0C000 + i, and a TX model that returns done 1 cycle after each start -> bytes received are A0,B0,C0,00, A0,B0,C0,01, …, A0,B0,C0,1F (128 bytes in total); o_done fires exactly once, 353 cycles after the first REQ.
- TX model with a done delay of 20 cycles -> each o_tx_data holds its value throughout WAIT_TX; only one o_tx_start per byte; byte order is unchanged.
- Extra i_start pulses at cycles 5 and 100 of a dump -> byte stream and o_done timing are identical to the first scenario.
- Spurious i_tx_done asserted in IDLE, REQ and SEND -> no state advance, no byte skipped.
- i_reset asserted after the 10th byte -> the next cycle has o_busy=0, all outputs 0, and no o_done; a following i_start restarts the dump from address 0 with byte A0.
- Monitor o_mem_enable/o_mem_read over a full dump -> each is high for exactly 32 single cycles, with addresses 0..31 in order, and no write strobe ever appears.
